// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding,
// control state encoding and the prefetch FIFO entry layout.
package instruction_fetch_unit_pkg;

    // RISC-V "addi x0, x0, 0"; decode treats this word as a bubble.
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs; head is combinational
// so a freshly pushed word is visible to decode right after its edge.
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; validity is tracked entirely by count.
    always_ff @(posedge clock) begin
        if (push && !reset && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline stage 1: issues word fetches to instruction memory, buffers them in
// a small prefetch FIFO and redirects on flush, draining any in-flight request.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    logic [31:0]    drain_addr;
    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           req;
    logic           accepted;
    logic           push;
    logic           pop;
    logic           empty;

    // Request depends only on registered state, never on stall_i.
    assign req      = !reset_i && ((state == DRAIN) || (count < FULL_COUNT));
    assign accepted = req && imem_ack_i;
    assign push     = (state == FETCH) && accepted && !flush_i;
    assign empty    = (count == '0);
    assign pop      = !empty && !stall_i && !flush_i;

    assign push_entry = '{pc: fetch_pc, instr: imem_data_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock_i),
        .reset     (reset_i),
        .push      (push),
        .pop       (pop),
        .clear     (flush_i),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    // A flush with a request still outstanding must wait for its ack in DRAIN,
    // keeping the old address on the bus so the handshake stays well formed.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            drain_addr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush_i) begin
                        fetch_pc <= branch_target_i;
                        if (req && !imem_ack_i) begin
                            drain_addr <= fetch_pc;
                            state      <= DRAIN;
                        end
                    end else if (push) begin
                        fetch_pc <= next_word(fetch_pc);
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        fetch_pc <= branch_target_i;
                    end
                    if (imem_ack_i) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = (state == DRAIN) ? drain_addr : fetch_pc;
    assign instruction_o = (reset_i || empty) ? NOP   : head.instr;
    assign pc_o          = (reset_i || empty) ? '0    : head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction
// memory whose data word is 32'h1000_0000 | address.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;

    logic        auto_ack;
    logic        manual_ack;

    int total;
    int bad;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .imem_addr_o     (imem_addr),
        .imem_req_o      (imem_req),
        .imem_ack_i      (imem_ack),
        .imem_data_i     (imem_data),
        .instruction_o   (instruction),
        .pc_o            (pc),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (branch_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: zero-wait mode acks whatever is requested, else the bench acks by hand.
    assign imem_ack  = auto_ack ? imem_req : manual_ack;
    assign imem_data = 32'h1000_0000 | imem_addr;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1ns later, well clear of rising edges.
    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic [31:0] t, input logic a);
        @(negedge clock);
        reset         = r;
        stall         = s;
        flush         = f;
        branch_target = t;
        manual_ack    = a;
        #1;
    endtask

    task automatic doReset(input logic zero_wait);
        auto_ack = zero_wait;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_target = 32'h0;
        manual_ack    = 1'b0;
        auto_ack      = 1'b0;

        // Reset state
        doReset(1'b0);
        checkOutput("rst_req",   {31'b0, imem_req}, 32'h0);
        checkOutput("rst_instr", instruction, NOP);
        checkOutput("rst_pc",    pc, 32'h0);

        // Zero-wait streaming
        $display("[TB] zero-wait streaming");
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("zw_empty_instr", instruction, NOP);
        checkOutput("zw_first_addr",  imem_addr, 32'h0);
        checkOutput("zw_first_req",   {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("zw_pc",    pc, 32'(i * 4));
            checkOutput("zw_instr", instruction, 32'h1000_0000 | 32'(i * 4));
        end

        // Stall fills the FIFO and drops the request
        $display("[TB] stall backpressure");
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("st_hold_pc", pc, 32'h0);
            if (i > 0) checkOutput("st_req_low", {31'b0, imem_req}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("st_rel_pc0", pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("st_rel_pc4", pc, 32'h4);
        checkOutput("st_req_back", {31'b0, imem_req}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("st_rel_pc8", pc, 32'h8);

        // Delayed ack
        $display("[TB] delayed ack");
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("dl_addr_stable", imem_addr, 32'h0);
            checkOutput("dl_req_held",    {31'b0, imem_req}, 32'h1);
            checkOutput("dl_nop",         instruction, NOP);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("dl_nop_at_ack", instruction, NOP);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("dl_delivered", instruction, 32'h1000_0000);
        checkOutput("dl_next_addr", imem_addr, 32'h4);

        // Flush while a request is pending
        $display("[TB] flush with request pending");
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("fl_drain_req",  {31'b0, imem_req}, 32'h1);
        checkOutput("fl_drain_addr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("fl_late_dropped", instruction, NOP);
        checkOutput("fl_target_addr",  imem_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("fl_pc200",    pc, 32'h200);
        checkOutput("fl_instr200", instruction, 32'h1000_0200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("fl_pc204", pc, 32'h204);

        // Flush coinciding with ack while stalled
        $display("[TB] flush with ack and stall");
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("fa_empty_instr", instruction, NOP);
        checkOutput("fa_empty_pc",    pc, 32'h0);
        checkOutput("fa_target_addr", imem_addr, 32'h300);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("fa_pc300", pc, 32'h300);

        // Reset while draining
        $display("[TB] reset in drain");
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_drain_addr", imem_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_req_low", {31'b0, imem_req}, 32'h0);
        checkOutput("rd_nop",     instruction, NOP);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_reset_addr", imem_addr, 32'h0);
        checkOutput("rd_req_back",   {31'b0, imem_req}, 32'h1);
        checkOutput("rd_nop_after",  instruction, NOP);

        // Fetch address wraps past the top of the address space
        $display("[TB] address wrap");
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wr_pc_top",   pc, 32'hFFFF_FFFC);
        checkOutput("wr_addr_zero", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wr_pc_zero",  pc, 32'h0);
        checkOutput("wr_instr",    instruction, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Stage 1 of the pipeline. Fetches instruction words from instruction memory and presents them with their PC to instruction_decode_unit on instruction_o/pc_o. A small prefetch FIFO absorbs decode stalls and memory latency. On flush it redirects to a branch target and discards stale or in-flight fetches.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 2, prefetch entries (power of two, 2..8)

Ports:
clock_i  in  1  single clock, rising edge
reset_i  in  1  synchronous, active-high
imem_addr_o  out  32  fetch address; word aligned (bits [1:0] = 0)
imem_req_o  out  1  fetch request; held until acked
imem_ack_i  in  1  imem_data_i valid for imem_addr_o this cycle
imem_data_i  in  32  fetched instruction word
instruction_o  out  32  FIFO head to decode; `NOP when empty
pc_o  out  32  address of instruction_o; 0 when empty
stall_i  in  1  from decode stall_o; hold head
flush_i  in  1  redirect to branch_target_i
branch_target_i  in  32  redirect address, word aligned

Behaviour:
- Reset (sync, reset_i high at edge): fetch_pc=RESET_PC, FIFO count=0, state=FETCH, discard target=0. While reset_i is high: imem_req_o=0, instruction_o=`NOP, pc_o=0.
- Memory handshake: address stable while imem_req_o is high. At most one request outstanding. Ack may arrive the same cycle as req (zero wait) or any later cycle.
- imem_addr_o = fetch_pc in FETCH and drain_addr in DRAIN.
- imem_req_o = (state==DRAIN) | (state==FETCH & count<FIFO_DEPTH). Registered count only, so there is no combinational path from stall_i.
- FETCH, ack, no flush: push {imem_data_i, fetch_pc}; fetch_pc += 4 (wraps modulo 2^32).
- Pop: when count>0 and stall_i=0 and flush_i=0, the head advances at the edge. Push and pop in the same cycle leave count unchanged. Push is never issued while full.
- Output latency: a word acked at edge N appears on instruction_o after edge N when the FIFO was empty.
- Flush (priority over stall, push and pop): FIFO cleared at the edge.
  - FETCH with req high and no ack this cycle: drain_addr=fetch_pc, fetch_pc=branch_target_i, go to DRAIN.
  - Otherwise (ack this cycle, or no request): acked data is discarded, fetch_pc=branch_target_i, stay in FETCH.
- DRAIN: req held on drain_addr. On ack, data is discarded and state goes to FETCH. Flush in DRAIN updates fetch_pc only.
- Output while empty: instruction_o=`NOP, pc_o=0. Decode treats `NOP as a bubble.
- Reset mid-request or in DRAIN: go to FETCH at RESET_PC. The memory side is reset in the same cycle.

Decomposition:
- Shared defines file: `NOP encoding, FETCH/DRAIN state encodings (1 bit).
- Sub-module fetch_fifo: synchronous FIFO, 64-bit entries {pc,instr}, DEPTH parameter, push/pop/clear inputs, count output, combinational head.
- Control FSM and fetch_pc stay in instruction_fetch_unit.

Test Plan:
- Zero-wait memory (ack = req, data = 32'h1000_0000|addr), stall_i=0: pc_o shows 0,4,8,C on consecutive cycles; instruction_o = 32'h1000_0000|pc_o.
- stall_i held high 4 cycles after the first word: pc_o stays 0; FIFO fills to 2; imem_req_o drops. Release stall: pc_o=4,8 with no gap, and req reasserts.
- Ack delayed 3 cycles: imem_addr_o stable through the wait; instruction_o=`NOP until delivery.
- flush_i with branch_target_i=32'h200 while a request is pending: state goes to DRAIN; the late ack data never appears. The next pc_o values are 200, 204.
- flush_i on the same cycle as ack and stall_i=1: data dropped, FIFO emptied, the next fetch address is the target.
- reset_i asserted for one cycle in DRAIN: imem_req_o=0 that cycle; the next fetch address is RESET_PC; instruction_o=`NOP.
